// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA state encoding and default widths
package dma_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

endpackage

// File: rtl/dma_fifo.sv
// rtl/dma_fifo.sv - synchronous FIFO with first-word head output
module dma_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_writer.sv
// rtl/dma_writer.sv - stream-to-memory write DMA with decoupling FIFO
module dma_writer #(
  parameter int DATA_W     = dma_pkg::DATA_W,
  parameter int ADDR_W     = dma_pkg::ADDR_W,
  parameter int LEN_W      = dma_pkg::LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAdress,
  input  logic [LEN_W-1:0]  length,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] dataIn,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAdress,
  output logic [DATA_W-1:0] memData,
  input  logic              memBusy,
  output logic              busy,
  output logic              done
);

  import dma_pkg::*;

  dma_state_t        state;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  acc_cnt;
  logic [LEN_W-1:0]  wr_cnt;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              complete;
  logic              issue;

  assign inReady  = (state == RUN) && !fifo_full && (acc_cnt != '0);
  assign push     = inValid && inReady;
  assign complete = memWrite && !memBusy;
  assign issue    = (state == RUN) && (!memWrite || complete) && !fifo_empty;

  dma_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(dataIn),
    .pop  (issue),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // addr_reg holds the address of the next write to issue, so it advances on issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      addr_reg  <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      memWrite  <= 1'b0;
      memAdress <= '0;
      memData   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            addr_reg <= startAdress;
            acc_cnt  <= length;
            wr_cnt   <= length;
            if (length == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push)     acc_cnt <= acc_cnt - LEN_W'(1);
          if (complete) wr_cnt  <= wr_cnt - LEN_W'(1);
          if (issue) begin
            memWrite  <= 1'b1;
            memAdress <= addr_reg;
            memData   <= fifo_rdata;
            addr_reg  <= addr_reg + ADDR_W'(1);
          end else if (complete) begin
            memWrite <= 1'b0;
          end
          if (complete && (wr_cnt == LEN_W'(1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // zero-length transfers enter with done low and spend one extra cycle here
          busy <= 1'b0;
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_writer.sv
// tb/tb_dma_writer.sv - randomized bench for dma_writer against a queue model
module tb_dma_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] startAdress;
  logic [15:0] length;
  logic        inValid;
  logic        inReady;
  logic [15:0] dataIn;
  logic        memWrite;
  logic [15:0] memAdress;
  logic [15:0] memData;
  logic        memBusy;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dma_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .startAdress(startAdress),
    .length     (length),
    .inValid    (inValid),
    .inReady    (inReady),
    .dataIn     (dataIn),
    .memWrite   (memWrite),
    .memAdress  (memAdress),
    .memData    (memData),
    .memBusy    (memBusy),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  int cyc = 0;

  // phase: 0 idle, 1 running, 2 zero-length wait, 3 done pulse
  int          m_phase = 0;
  logic [15:0] q[$];
  int          m_acc = 0;
  int          m_wr = 0;
  logic [15:0] m_next = 0;
  logic [15:0] m_addr = 0;
  logic [15:0] m_data = 0;
  bit          m_pend = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wcyc[$];
  int          done_cyc = 0;
  bit          done_seen = 0;
  int          acc_seen = 0;

  function automatic bit m_ready();
    return (m_phase == 1) && (q.size() < 4) && (m_acc != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit compl, pushed, issued;
    cyc++;
    if (!rst) begin
      m_phase = 0; q.delete(); m_acc = 0; m_wr = 0;
      m_next = 0; m_addr = 0; m_data = 0; m_pend = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_next = startAdress; m_acc = length; m_wr = length;
          m_phase = (length == 0) ? 2 : 1;
        end
        2: m_phase = 3;
        3: m_phase = 0;
        default: begin
          compl  = m_pend && !memBusy;
          pushed = inValid && m_ready();
          issued = (!m_pend || compl) && (q.size() > 0);
          if (compl) m_wr--;
          if (issued) begin
            m_data = q.pop_front(); m_addr = m_next; m_next++; m_pend = 1;
          end else if (compl) begin
            m_pend = 0;
          end
          if (pushed) begin q.push_back(dataIn); m_acc--; end
          if (compl && m_wr == 0) m_phase = 3;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("memWrite", memWrite, m_pend);
      chk("memAdress", memAdress, m_addr);
      chk("memData", memData, m_data);
      chk("inReady", inReady, m_ready());
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 3);
      if (memWrite && !memBusy) begin
        wa.push_back(memAdress); wd.push_back(memData); wcyc.push_back(cyc);
      end
      if (inValid && inReady) acc_seen++;
      if (done) begin done_seen = 1; done_cyc = cyc; end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wcyc.delete();
    done_seen = 0; acc_seen = 0;
  endtask

  task automatic start_xfer(input logic [15:0] a, input logic [15:0] n);
    inValid = 0; memBusy = 0;
    cycle();
    start = 1; startAdress = a; length = n;
    cycle();
    start = 0; startAdress = $urandom; length = $urandom;
  endtask

  // bprob<0 selects a 3-cycle stall on the second write; abort_at>=0 resets after that many writes
  task automatic run(input logic [15:0] a, input logic [15:0] n, input logic [15:0] base,
                     input int vprob, input int bprob, input bit seqdata,
                     input bit inject, input int abort_at);
    int stall_left = 0;
    bit stalled = 0;
    clear_log();
    start_xfer(a, n);
    for (int i = 0; i < 3000; i++) begin
      inValid = ($urandom % 100) < vprob;
      dataIn  = seqdata ? base + 16'(acc_seen) : 16'($urandom);
      if (bprob < 0) begin
        if (!stalled && wa.size() == 1 && memWrite) begin stall_left = 3; stalled = 1; end
        memBusy = stall_left > 0;
        if (stall_left > 0) stall_left--;
      end else begin
        memBusy = ($urandom % 100) < bprob;
      end
      start = inject && (i == 3);
      startAdress = 16'h9000; length = 16'd7;
      cycle();
      if (done_seen) break;
      if (abort_at >= 0 && wa.size() >= abort_at) break;
    end
    start = 0; inValid = 0; memBusy = 0;
    if (abort_at < 0) chk("done_reached", done_seen, 1);
  endtask

  initial begin
    rst = 0; start = 0; startAdress = 0; length = 0;
    inValid = 0; dataIn = 0; memBusy = 0;
    cycle();
    check_en = 1;
    cycle();
    chk("reset_inReady", inReady, 0);
    chk("reset_memWrite", memWrite, 0);
    rst = 1;

    // basic back-to-back transfer
    run(16'h0100, 4, 16'h00A0, 100, 0, 1, 0, -1);
    chk("basic_count", wa.size(), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk("basic_addr", wa[i], 16'h0100 + 16'(i));
      chk("basic_data", wd[i], 16'h00A0 + 16'(i));
      if (i > 0) chk("basic_consecutive", wcyc[i] - wcyc[i-1], 1);
    end
    if (wa.size() == 4) chk("basic_done_timing", done_cyc - wcyc[3], 1);

    // stalled second write
    run(16'h0200, 3, 16'h00B0, 100, -1, 1, 0, -1);
    chk("stall_count", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("stall_addr", wa[i], 16'h0200 + 16'(i));
      chk("stall_data", wd[i], 16'h00B0 + 16'(i));
    end

    // address wrap
    run(16'hFFFE, 4, 16'h0010, 80, 30, 1, 0, -1);
    chk("wrap_count", wa.size(), 4);
    if (wa.size() == 4) begin
      chk("wrap_a0", wa[0], 16'hFFFE);
      chk("wrap_a1", wa[1], 16'hFFFF);
      chk("wrap_a2", wa[2], 16'h0000);
      chk("wrap_a3", wa[3], 16'h0001);
    end

    // zero length
    begin
      int s;
      clear_log();
      start_xfer(16'h0050, 0);
      s = cyc;
      for (int i = 0; i < 5; i++) cycle();
      chk("zero_done_seen", done_seen, 1);
      chk("zero_done_timing", done_cyc - s, 1);
      chk("zero_no_write", wa.size(), 0);
    end

    // start pulse during RUN is ignored
    run(16'h0300, 6, 16'h00C0, 60, 20, 1, 1, -1);
    chk("inject_count", wa.size(), 6);
    for (int i = 0; i < 6 && i < wa.size(); i++) chk("inject_addr", wa[i], 16'h0300 + 16'(i));

    // excess input
    run(16'h0400, 2, 16'h00D0, 100, 0, 1, 0, -1);
    for (int i = 0; i < 3; i++) begin inValid = 1; cycle(); end
    inValid = 0;
    chk("excess_accepted", acc_seen, 2);
    chk("excess_written", wa.size(), 2);

    // reset in the middle of a transfer
    run(16'h0500, 5, 16'h00E0, 100, 0, 1, 0, 2);
    rst = 0;
    cycle();
    rst = 1;
    @(negedge clk);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_memAdress", memAdress, 0);
    chk("rst_memData", memData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inReady", inReady, 0);
    run(16'h0010, 1, 16'h0077, 100, 0, 1, 0, -1);
    chk("post_rst_count", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("post_rst_addr", wa[0], 16'h0010);
      chk("post_rst_data", wd[0], 16'h0077);
    end

    // randomized transfers
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 24);
      run(16'($urandom), 16'(n), 0, $urandom_range(30, 100), $urandom_range(0, 60), 0, 0, -1);
      chk("rand_count", wa.size(), n);
    end

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
